// File: rtl/ifm_window_reader.sv
// Streams KxK convolution windows out of the padded IFM buffer, one PE-channel word per transfer.
// Reads are issued on credit against a 2-entry output FIFO, so backpressure never overflows it.
module ifm_window_reader #(
  parameter int PE        = 16,
  parameter int K         = 3,
  parameter int ADDR_STEP = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [15:0]     IFM_C,
  input  logic [15:0]     IFM_W,
  input  logic            padding,
  input  logic            stride,
  input  logic [31:0]     base_addr,
  output logic            rd_en,
  output logic [31:0]     rd_addr,
  input  logic [PE*8-1:0] rd_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [PE*8-1:0] out_data,
  output logic            out_win_last,
  output logic            out_frame_last,
  output logic            busy,
  output logic            done
);

  localparam int DW = PE * 8;
  localparam int KW = (K > 1) ? $clog2(K) : 1;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  logic [1:0]    state;
  logic [31:0]   pw, cg_n, ow, base;
  logic          str;
  logic [KW-1:0] kx, ky;
  logic [31:0]   cg, ox, oy;

  logic [31:0] pw_in, cg_in, ow_in;
  logic        degenerate;

  always_comb begin
    pw_in      = {16'd0, IFM_W} + {30'd0, padding, 1'b0};
    cg_in      = {16'd0, IFM_C} / 32'(PE);
    ow_in      = ((pw_in - 32'(K)) >> stride) + 32'd1;
    degenerate = (pw_in < 32'(K)) || (cg_in == 32'd0);
  end

  logic kx_last, ky_last, cg_last, ox_last, oy_last;
  logic win_last_i, frame_last_i;

  always_comb begin
    kx_last      = (kx == KW'(K - 1));
    ky_last      = (ky == KW'(K - 1));
    cg_last      = (cg == cg_n - 32'd1);
    ox_last      = (ox == ow - 32'd1);
    oy_last      = (oy == ow - 32'd1);
    win_last_i   = kx_last && ky_last;
    frame_last_i = win_last_i && cg_last && ox_last && oy_last;
  end

  logic [31:0] row, col, addr;

  always_comb begin
    row  = (oy << str) + 32'(ky);
    col  = (ox << str) + 32'(kx);
    addr = base + ((row * pw + col) * cg_n + cg) * 32'(ADDR_STEP);
  end

  // Read return stage: data arrives one cycle after rd_en, tags ride alongside.
  logic in_valid, in_wl, in_fl;

  logic [DW-1:0] mem_data [0:1];
  logic [1:0]    mem_wl, mem_fl;
  logic          wr_ptr, rd_ptr;
  logic [1:0]    occ;
  logic [1:0]    credit_used;
  logic          empty, push, pop, mem_pop;

  always_comb begin
    credit_used = occ + {1'b0, in_valid};
    rd_en       = (state == ISSUE) && (credit_used < 2'd2);
    rd_addr     = rd_en ? addr : '0;
    busy        = (state == ISSUE) || (state == DRAIN);
    done        = (state == DONE);
  end

  // An empty FIFO is bypassed so the returning word is visible in its arrival cycle.
  always_comb begin
    empty          = (occ == 2'd0);
    out_valid      = !empty || in_valid;
    out_data       = '0;
    out_win_last   = 1'b0;
    out_frame_last = 1'b0;
    if (!empty) begin
      out_data       = mem_data[rd_ptr];
      out_win_last   = mem_wl[rd_ptr];
      out_frame_last = mem_fl[rd_ptr];
    end else if (in_valid) begin
      out_data       = rd_data;
      out_win_last   = in_wl;
      out_frame_last = in_fl;
    end
    pop     = out_valid && out_ready;
    push    = in_valid && !(empty && out_ready);
    mem_pop = pop && !empty;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      pw    <= '0;
      cg_n  <= '0;
      ow    <= '0;
      base  <= '0;
      str   <= 1'b0;
      kx    <= '0;
      ky    <= '0;
      cg    <= '0;
      ox    <= '0;
      oy    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            pw    <= pw_in;
            cg_n  <= cg_in;
            ow    <= ow_in;
            base  <= base_addr;
            str   <= stride;
            kx    <= '0;
            ky    <= '0;
            cg    <= '0;
            ox    <= '0;
            oy    <= '0;
            state <= degenerate ? DONE : ISSUE;
          end
        end
        ISSUE: begin
          if (rd_en) begin
            if (frame_last_i) state <= DRAIN;
            if (!kx_last) kx <= kx + KW'(1);
            else begin
              kx <= '0;
              if (!ky_last) ky <= ky + KW'(1);
              else begin
                ky <= '0;
                if (!cg_last) cg <= cg + 32'd1;
                else begin
                  cg <= '0;
                  if (!ox_last) ox <= ox + 32'd1;
                  else begin
                    ox <= '0;
                    oy <= oy + 32'd1;
                  end
                end
              end
            end
          end
        end
        DRAIN: begin
          if (pop && out_frame_last) state <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_valid <= 1'b0;
      in_wl    <= 1'b0;
      in_fl    <= 1'b0;
    end else begin
      in_valid <= rd_en;
      in_wl    <= rd_en && win_last_i;
      in_fl    <= rd_en && frame_last_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < 2; i++) mem_data[i] <= '0;
      mem_wl <= '0;
      mem_fl <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      occ    <= '0;
    end else begin
      if (push) begin
        mem_data[wr_ptr] <= rd_data;
        mem_wl[wr_ptr]   <= in_wl;
        mem_fl[wr_ptr]   <= in_fl;
        wr_ptr           <= ~wr_ptr;
      end
      if (mem_pop) rd_ptr <= ~rd_ptr;
      case ({push, mem_pop})
        2'b10:   occ <= occ + 2'd1;
        2'b01:   occ <= occ - 2'd1;
        default: occ <= occ;
      endcase
    end
  end

endmodule

// File: tb/tb_ifm_window_reader.sv
// Self-checking bench for ifm_window_reader: table-driven frames plus random configs,
// compared against a loop-nest reference model and a synthetic buffer memory.
module tb_ifm_window_reader;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [15:0]  ifm_c = '0, ifm_w = '0;
  logic         padding = 1'b0, stride = 1'b0;
  logic [31:0]  base_addr = '0;
  logic         rd_en;
  logic [31:0]  rd_addr;
  logic [127:0] rd_data = '0;
  logic         out_valid, out_ready = 1'b0;
  logic [127:0] out_data;
  logic         out_win_last, out_frame_last, busy, done;

  ifm_window_reader #(.PE(16), .K(3), .ADDR_STEP(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .IFM_C(ifm_c), .IFM_W(ifm_w), .padding(padding), .stride(stride),
    .base_addr(base_addr),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_win_last(out_win_last), .out_frame_last(out_frame_last),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  function automatic logic [127:0] pat(input logic [31:0] a);
    return {a ^ 32'hDEADBEEF, ~a, a + 32'h12345678, a};
  endfunction

  // Buffer model: 1-cycle read latency, garbage when not read.
  always @(posedge clk)
    rd_data <= rd_en ? pat(rd_addr) : {$urandom, $urandom, $urandom, $urandom};

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    int          w;
    int          c;
    bit          pad;
    bit          str;
    logic [31:0] base;
    int          ready_mode;   // 0 = always ready, 1 = random
    int          exp_n;        // -1 = not checked against table
    int          exp_done;     // 0 = not checked
    int          reset_after;  // 0 = no reset
    int          busy_start_at;
  } vec_t;

  logic [31:0] exp_addr[$];
  bit          exp_wl[$], exp_fl[$];
  logic [31:0] rec_addr[$];

  task automatic build_model(input vec_t v);
    int unsigned pw, cgn, s, ow;
    logic [31:0] a;
    exp_addr.delete(); exp_wl.delete(); exp_fl.delete();
    pw  = v.w + 2 * v.pad;
    cgn = v.c / 16;
    s   = v.str + 1;
    if (pw < 3 || cgn == 0) return;
    ow = (pw - 3) / s + 1;
    for (int unsigned oy = 0; oy < ow; oy++)
      for (int unsigned ox = 0; ox < ow; ox++)
        for (int unsigned g = 0; g < cgn; g++)
          for (int unsigned ky = 0; ky < 3; ky++)
            for (int unsigned kx = 0; kx < 3; kx++) begin
              a = v.base + 32'((((oy * s + ky) * pw + (ox * s + kx)) * cgn + g) * 4);
              exp_addr.push_back(a);
              exp_wl.push_back(kx == 2 && ky == 2);
              exp_fl.push_back(kx == 2 && ky == 2 && g == cgn - 1 && ox == ow - 1 && oy == ow - 1);
            end
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_ctl"}, {rd_en, rd_addr, out_valid, out_win_last, out_frame_last, busy, done}, '0);
    check({name, "_data"}, out_data, '0);
  endtask

  task automatic run_frame(input vec_t v);
    int n, c, rd_idx, acc, last_acc_c, budget;
    bit finished, prev_stall;
    logic [127:0] prev_data;
    logic prev_wl, prev_fl;
    build_model(v);
    n = exp_addr.size();
    rec_addr.delete();
    @(negedge clk);
    ifm_w = 16'(v.w); ifm_c = 16'(v.c); padding = v.pad; stride = v.str;
    base_addr = v.base; start = 1'b1; out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    c = 1; rd_idx = 0; acc = 0; last_acc_c = -1; finished = 0; prev_stall = 0;
    prev_data = '0; prev_wl = 0; prev_fl = 0;
    budget = n * 20 + 50;
    while (!finished && c < budget) begin
      start = (c == v.busy_start_at);
      if (start) base_addr = v.base + 32'h1000;
      out_ready = (v.ready_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      if (rd_en) begin
        rec_addr.push_back(rd_addr);
        if (rd_idx < n) check("rd_addr", rd_addr, exp_addr[rd_idx]);
        else check("extra_read", 1, 0);
        if (rd_idx == 0) check("first_read_cycle", c, 1);
        rd_idx++;
        check("outstanding_le2", (rd_idx - acc) <= 2, 1);
      end
      if (prev_stall) begin
        check("stall_valid", out_valid, 1);
        check("stall_data", out_data, prev_data);
        check("stall_tags", {out_win_last, out_frame_last}, {prev_wl, prev_fl});
      end
      if (out_valid && out_ready) begin
        if (acc < n) begin
          check("out_data", out_data, pat(exp_addr[acc]));
          check("out_tags", {out_win_last, out_frame_last}, {exp_wl[acc], exp_fl[acc]});
        end else check("extra_word", 1, 0);
        if (acc == 0 && v.ready_mode == 0) check("first_valid_cycle", c, 2);
        acc++;
        last_acc_c = c;
      end
      if (done) begin
        if (n > 0) check("done_after_last", c, last_acc_c + 1);
        if (v.exp_done > 0) check("done_cycle", c, v.exp_done);
        if (v.exp_n >= 0) check("word_count", acc, v.exp_n);
        check("model_count", acc, n);
        check("busy_at_done", busy, 0);
        finished = 1;
        start = 1'b1;  // coincides with done: must be ignored
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        check("after_done", {busy, done, rd_en}, 3'b000);
      end else begin
        check("busy", busy, n > 0);
        if (v.reset_after > 0 && acc == v.reset_after) begin
          rst_n = 1'b0;
          #1;
          check_reset_outputs("async_reset");
          @(posedge clk);
          #1;
          check_reset_outputs("reset_hold");
          @(negedge clk);
          rst_n = 1'b1;
          finished = 1;
        end
      end
      if (!finished) begin
        prev_stall = out_valid && !out_ready;
        prev_data  = out_data;
        prev_wl    = out_win_last;
        prev_fl    = out_frame_last;
        @(posedge clk);
        @(negedge clk);
        c++;
      end
    end
    if (!finished) check("timeout", 0, 1);
    start = 1'b0;
  endtask

  vec_t tbl[10];
  vec_t rv;
  logic [31:0] first9[9];

  initial begin
    first9 = '{32'd0, 32'd4, 32'd8, 32'd24, 32'd28, 32'd32, 32'd48, 32'd52, 32'd56};
    //          w  c   pad str base          rdy n    done rst bs
    tbl[0] = '{4, 16, 1, 0, 32'h0,         0, 144, 146, 0,  0};
    tbl[1] = '{4, 32, 1, 1, 32'h0,         0, 72,  74,  0,  0};
    tbl[2] = '{4, 16, 1, 0, 32'h0,         1, 144, 0,   0,  0};
    tbl[3] = '{1, 16, 0, 0, 32'h0,         0, 0,   1,   0,  0};
    tbl[4] = '{4, 0,  1, 0, 32'h0,         0, 0,   1,   0,  0};
    tbl[5] = '{4, 16, 1, 0, 32'h0,         0, -1,  0,   50, 0};
    tbl[6] = '{4, 16, 1, 0, 32'h0,         0, 144, 146, 0,  0};
    tbl[7] = '{4, 16, 1, 0, 32'h200,       0, 144, 146, 0,  10};
    tbl[8] = '{5, 16, 0, 1, 32'h100,       0, 36,  38,  0,  0};
    tbl[9] = '{3, 48, 0, 0, 32'hFFFF_FF00, 1, 27,  0,   0,  0};

    rst_n = 1'b0;
    #1;
    check_reset_outputs("por");
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      run_frame(tbl[i]);
      if (i == 0) begin
        check("basic_addr_count", rec_addr.size(), 144);
        for (int j = 0; j < 9; j++)
          if (j < rec_addr.size()) check("basic_first9", rec_addr[j], first9[j]);
      end
      if (i == 1 && rec_addr.size() > 18) begin
        check("s2_ox1_cg0", rec_addr[18], 32'd16);
        check("s2_ox0_cg1", rec_addr[9], 32'd4);
      end
      if (i == 3 || i == 4) check("degen_no_reads", rec_addr.size(), 0);
      if (i == 6 && rec_addr.size() > 0) check("restart_addr0", rec_addr[0], 32'd0);
      if (i == 7) begin
        check("busy_start_count", rec_addr.size(), 144);
        if (rec_addr.size() > 143) check("busy_start_lastaddr", rec_addr[143], 32'h200 + 32'd140);
      end
    end

    for (int r = 0; r < 6; r++) begin
      rv.w = $urandom_range(1, 7);
      rv.c = 16 * $urandom_range(0, 3);
      rv.pad = 1'($urandom_range(0, 1));
      rv.str = 1'($urandom_range(0, 1));
      rv.base = $urandom;
      rv.ready_mode = 1;
      rv.exp_n = -1;
      rv.exp_done = 0;
      rv.reset_after = 0;
      rv.busy_start_at = 0;
      run_frame(rv);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
